// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter
//   Request arbiter and bus-hold sequencer for the 4-channel DMA controller.
//   Pin requests are polarity-normalised and synchronised, then masked and
//   merged with software requests. The block runs the HRQ/HLDA handshake
//   with the CPU and picks one channel by fixed or rotating priority. It
//   holds DACK and the channel index until timing control signals that the
//   transfer is done, or until the CPU takes the bus back.
//
//   Build option: define DMA_ARB_HLDA_TIMEOUT_EN to abandon a hold request
//   that has not been acknowledged within HLDA_TIMEOUT cycles.
//
// Ports
//   CLK, RESET_N    clock (rising edge), async active-low reset
//   DREQ[3:0]       raw request pins, polarity set by cmdDreqActLow
//   HLDA            hold acknowledge from the CPU
//   maskReg[3:0]    1 = ignore that channel's DREQ pin
//   swReq[3:0]      software requests (not maskable)
//   cmdDisable      blocks the start of new hold cycles
//   cmdRotPri       1 = rotating priority, 0 = fixed (ch0 highest)
//   cmdDreqActLow   DREQ pins are active low
//   cmdDackActHigh  DACK pins are active high
//   xferDone        one-cycle pulse: the granted channel's service is done
//   HRQ             registered hold request to the CPU
//   DACK[3:0]       channel acknowledges, polarity applied
//   grantValid      a channel is in service
//   grantCh[1:0]    index of the granted channel
//   validDreq[3:0]  valid requests, for status bits 7:4
//   hldaTimeout     one-cycle pulse when a hold request is abandoned
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | no hold activity; waiting for a valid request
// WAIT_HLDA | HRQ high, waiting for the CPU to acknowledge
// SERVICE   | bus held, one channel granted and frozen
// RELEASE   | HRQ low, waiting for HLDA to drop before the next hold
module dma_priority_arbiter #(
  parameter int DREQ_SYNC_STAGES = 2,
  parameter int HLDA_TIMEOUT     = 64
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] DREQ,
  input  logic       HLDA,
  input  logic [3:0] maskReg,
  input  logic [3:0] swReq,
  input  logic       cmdDisable,
  input  logic       cmdRotPri,
  input  logic       cmdDreqActLow,
  input  logic       cmdDackActHigh,
  input  logic       xferDone,
  output logic       HRQ,
  output logic [3:0] DACK,
  output logic       grantValid,
  output logic [1:0] grantCh,
  output logic [3:0] validDreq,
  output logic       hldaTimeout
);

  if (DREQ_SYNC_STAGES < 1 || DREQ_SYNC_STAGES > 3 || HLDA_TIMEOUT < 1) begin : g_bad_param
    $error("dma_priority_arbiter: DREQ_SYNC_STAGES must be 1..3 and HLDA_TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HLDA = 2'd1,
    SERVICE   = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DREQ_SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0] sync_req;
  logic       any_req;

  logic       hrq_q, hrq_d;
  logic       grant_valid_q, grant_valid_d;
  logic [3:0] grant_oh_q, grant_oh_d;
  logic [1:0] grant_ch_q, grant_ch_d;
  logic [1:0] ptr_q, ptr_d;

  logic [1:0] search_base;
  logic [1:0] idx;
  logic [1:0] win_ch;
  logic       found;

`ifdef DMA_ARB_HLDA_TIMEOUT_EN
  localparam int CNT_W = (HLDA_TIMEOUT > 1) ? $clog2(HLDA_TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Normalise polarity before synchronising so the flops reset to "inactive".
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= DREQ ^ {4{cmdDreqActLow}};
      for (int i = 1; i < DREQ_SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_req  = sync_q[DREQ_SYNC_STAGES-1];
  assign validDreq = (sync_req & ~maskReg) | swReq;
  assign any_req   = |validDreq;

  // Fixed mode is simply a rotating search that always starts at channel 0.
  always_comb begin
    search_base = cmdRotPri ? ptr_q : 2'd0;
    win_ch      = search_base;
    found       = 1'b0;
    idx         = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = search_base + k[1:0];
      if (!found && validDreq[idx]) begin
        win_ch = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      hrq_q         <= 1'b0;
      grant_valid_q <= 1'b0;
      grant_oh_q    <= 4'h0;
      grant_ch_q    <= 2'd0;
      ptr_q         <= 2'd0;
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      hrq_q         <= hrq_d;
      grant_valid_q <= grant_valid_d;
      grant_oh_q    <= grant_oh_d;
      grant_ch_q    <= grant_ch_d;
      ptr_q         <= ptr_d;
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    hrq_d         = hrq_q;
    grant_valid_d = grant_valid_q;
    grant_oh_d    = grant_oh_q;
    grant_ch_d    = grant_ch_q;
    ptr_d         = ptr_q;
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!cmdDisable && any_req) begin
          hrq_d   = 1'b1;
          state_d = WAIT_HLDA;
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT_HLDA: begin
        if (HLDA && any_req) begin
          grant_ch_d    = win_ch;
          grant_oh_d    = 4'd1 << win_ch;
          grant_valid_d = 1'b1;
          state_d       = SERVICE;
        end else if (!any_req) begin
          hrq_d   = 1'b0;
          state_d = RELEASE;
        end
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
        // Only reached with a request pending and HLDA still low.
        else if (cnt_q == CNT_W'(HLDA_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          hrq_d     = 1'b0;
          state_d   = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      SERVICE: begin
        // xferDone wins over a simultaneous HLDA fall so the pointer advances.
        if (xferDone) begin
          grant_valid_d = 1'b0;
          grant_oh_d    = 4'h0;
          hrq_d         = 1'b0;
          if (cmdRotPri) begin
            ptr_d = grant_ch_q + 2'd1;
          end
          state_d = RELEASE;
        end else if (!HLDA) begin
          grant_valid_d = 1'b0;
          grant_oh_d    = 4'h0;
          hrq_d         = 1'b0;
          state_d       = RELEASE;
        end
      end
      RELEASE: begin
        hrq_d = 1'b0;
        if (!HLDA) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign HRQ        = hrq_q;
  assign grantValid = grant_valid_q;
  assign grantCh    = grant_ch_q;
  assign DACK       = cmdDackActHigh ? grant_oh_q : ~grant_oh_q;

`ifdef DMA_ARB_HLDA_TIMEOUT_EN
  assign hldaTimeout = timeout_q;
`else
  assign hldaTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter: fixed and rotating priority,
// masking and software requests, pin polarity, abort paths, async reset,
// and (when DMA_ARB_HLDA_TIMEOUT_EN is defined) the hold-request timeout.
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic       HLDA;
  logic [3:0] maskReg;
  logic [3:0] swReq;
  logic       cmdDisable;
  logic       cmdRotPri;
  logic       cmdDreqActLow;
  logic       cmdDackActHigh;
  logic       xferDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic       grantValid;
  logic [1:0] grantCh;
  logic [3:0] validDreq;
  logic       hldaTimeout;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  dma_priority_arbiter #(
    .DREQ_SYNC_STAGES(2),
    .HLDA_TIMEOUT    (8)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .DREQ          (DREQ),
    .HLDA          (HLDA),
    .maskReg       (maskReg),
    .swReq         (swReq),
    .cmdDisable    (cmdDisable),
    .cmdRotPri     (cmdRotPri),
    .cmdDreqActLow (cmdDreqActLow),
    .cmdDackActHigh(cmdDackActHigh),
    .xferDone      (xferDone),
    .HRQ           (HRQ),
    .DACK          (DACK),
    .grantValid    (grantValid),
    .grantCh       (grantCh),
    .validDreq     (validDreq),
    .hldaTimeout   (hldaTimeout)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_hrq(input string tag);
    int n;
    n = 0;
    while (HRQ !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk(tag, 4'(HRQ), 4'd1);
  endtask

  // One complete hold cycle ending with the FSM back in IDLE.
  task automatic grant_cycle(input string tag, input logic [1:0] exp_ch);
    wait_hrq({tag, "_hrq"});
    HLDA = 1'b1;
    tick();
    chk({tag, "_gv"}, 4'(grantValid), 4'd1);
    chk({tag, "_ch"}, 4'(grantCh), 4'(exp_ch));
    xferDone = 1'b1;
    tick();
    xferDone = 1'b0;
    chk({tag, "_done_gv"}, 4'(grantValid), 4'd0);
    chk({tag, "_done_hrq"}, 4'(HRQ), 4'd0);
    HLDA = 1'b0;
    tick();
  endtask

  initial begin
    RESET_N        = 1'b0;
    DREQ           = 4'h0;
    HLDA           = 1'b0;
    maskReg        = 4'h0;
    swReq          = 4'h0;
    cmdDisable     = 1'b0;
    cmdRotPri      = 1'b0;
    cmdDreqActLow  = 1'b0;
    cmdDackActHigh = 1'b0;
    xferDone       = 1'b0;

    #3;
    chk("rst_dack", DACK, 4'hF);
    chk("rst_hrq", 4'(HRQ), 4'd0);
    chk("rst_gv", 4'(grantValid), 4'd0);
    chk("rst_valid", validDreq, 4'h0);
    chk("rst_timeout", 4'(hldaTimeout), 4'd0);
    tick();
    tick();
    RESET_N = 1'b1;
    tick();

    // Fixed priority, DREQ = 0110 -> channel 1
    DREQ = 4'b0110;
    tick();
    chk("fix_hrq_c1", 4'(HRQ), 4'd0);
    tick();
    chk("fix_hrq_c2", 4'(HRQ), 4'd0);
    chk("fix_valid", validDreq, 4'b0110);
    tick();
    chk("fix_hrq_c3", 4'(HRQ), 4'd1);
    chk("fix_gv_wait", 4'(grantValid), 4'd0);
    tick();
    HLDA = 1'b1;
    tick();
    chk("fix_gv", 4'(grantValid), 4'd1);
    chk("fix_ch", 4'(grantCh), 4'd1);
    chk("fix_dack", DACK, 4'b1101);
    chk("fix_no_timeout", 4'(hldaTimeout), 4'd0);
    xferDone = 1'b1;
    DREQ     = 4'h0;
    tick();
    xferDone = 1'b0;
    chk("fix_done_hrq", 4'(HRQ), 4'd0);
    chk("fix_done_dack", DACK, 4'hF);
    chk("fix_done_gv", 4'(grantValid), 4'd0);
    tick();
    HLDA = 1'b0;
    tick();
    tick();
    chk("fix_idle_hrq", 4'(HRQ), 4'd0);

    // Rotating priority, all channels requesting
    cmdRotPri = 1'b1;
    DREQ      = 4'hF;
    grant_cycle("rot0", 2'd0);
    grant_cycle("rot1", 2'd1);
    grant_cycle("rot2", 2'd2);
    grant_cycle("rot3", 2'd3);
    grant_cycle("rot4", 2'd0);
    // Request withdrawn while waiting for HLDA
    DREQ = 4'h0;
    tick();
    chk("wd_hrq_up", 4'(HRQ), 4'd1);
    tick();
    tick();
    chk("wd_hrq_down", 4'(HRQ), 4'd0);
    chk("wd_gv", 4'(grantValid), 4'd0);
    tick();

    // Mask and software request
    cmdRotPri = 1'b0;
    maskReg   = 4'hF;
    DREQ      = 4'hF;
    repeat (4) tick();
    chk("mask_hrq", 4'(HRQ), 4'd0);
    chk("mask_valid", validDreq, 4'h0);
    swReq = 4'b1000;
    #1;
    chk("sw_valid", validDreq, 4'b1000);
    grant_cycle("sw", 2'd3);
    swReq = 4'h0;
    DREQ  = 4'h0;

    // Polarity: active-low DREQ pins, active-high DACK
    cmdDreqActLow = 1'b1;
    DREQ          = 4'hF;
    repeat (3) tick();
    maskReg        = 4'h0;
    cmdDackActHigh = 1'b1;
    cmdRotPri      = 1'b1;
    #1;
    chk("pol_dack_idle", DACK, 4'h0);
    chk("pol_valid_idle", validDreq, 4'h0);
    DREQ = 4'b1011;
    tick();
    tick();
    chk("pol_valid", validDreq, 4'b0100);
    wait_hrq("pol_hrq");
    HLDA = 1'b1;
    tick();
    chk("pol_ch", 4'(grantCh), 4'd2);
    chk("pol_dack", DACK, 4'b0100);
    chk("pol_gv", 4'(grantValid), 4'd1);
    // New requests during service must not move the grant
    DREQ = 4'b0001;
    repeat (3) tick();
    chk("frozen_ch", 4'(grantCh), 4'd2);
    chk("frozen_dack", DACK, 4'b0100);

    // CPU reclaim mid-service: pointer stays at 1
    HLDA = 1'b0;
    tick();
    chk("abort_gv", 4'(grantValid), 4'd0);
    chk("abort_hrq", 4'(HRQ), 4'd0);
    chk("abort_dack", DACK, 4'h0);
    tick();
    chk("abort_release_hrq", 4'(HRQ), 4'd0);
    tick();
    chk("abort_rehrq", 4'(HRQ), 4'd1);
    HLDA = 1'b1;
    tick();
    chk("abort_ptr_ch", 4'(grantCh), 4'd1);
    // xferDone together with HLDA fall: pointer advances to 2
    xferDone = 1'b1;
    HLDA     = 1'b0;
    tick();
    xferDone = 1'b0;
    chk("simul_gv", 4'(grantValid), 4'd0);
    tick();
    grant_cycle("simul_next", 2'd2);

    // Async reset in the middle of service
    wait_hrq("rst_mid_hrq");
    HLDA = 1'b1;
    tick();
    chk("rst_mid_ch", 4'(grantCh), 4'd3);
    chk("rst_mid_gv", 4'(grantValid), 4'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_hrq", 4'(HRQ), 4'd0);
    chk("arst_gv", 4'(grantValid), 4'd0);
    chk("arst_dack", DACK, 4'h0);
    cmdDisable = 1'b1;
    HLDA       = 1'b0;
    cmdRotPri  = 1'b0;
    tick();
    RESET_N = 1'b1;

    // Controller disable blocks only the start of a hold cycle
    repeat (4) tick();
    chk("dis_hrq", 4'(HRQ), 4'd0);
    chk("dis_valid", validDreq, 4'b1110);
    cmdDisable = 1'b0;
    tick();
    chk("en_hrq", 4'(HRQ), 4'd1);
    HLDA = 1'b1;
    tick();
    chk("en_ch", 4'(grantCh), 4'd1);
    cmdDisable = 1'b1;
    xferDone   = 1'b1;
    tick();
    xferDone = 1'b0;
    chk("dis_done_gv", 4'(grantValid), 4'd0);
    chk("dis_done_hrq", 4'(HRQ), 4'd0);
    HLDA = 1'b0;
    DREQ = 4'hF;
    repeat (3) tick();
    chk("dis_idle_hrq", 4'(HRQ), 4'd0);

`ifdef DMA_ARB_HLDA_TIMEOUT_EN
    cmdDreqActLow = 1'b0;
    DREQ          = 4'h0;
    cmdDisable    = 1'b0;
    repeat (4) tick();
    DREQ = 4'b0001;
    wait_hrq("to_hrq");
    repeat (7) tick();
    chk("to_early", 4'(hldaTimeout), 4'd0);
    chk("to_early_hrq", 4'(HRQ), 4'd1);
    tick();
    chk("to_pulse", 4'(hldaTimeout), 4'd1);
    chk("to_hrq_drop", 4'(HRQ), 4'd0);
    tick();
    chk("to_pulse_end", 4'(hldaTimeout), 4'd0);
    chk("to_hrq_low", 4'(HRQ), 4'd0);
    tick();
    chk("to_rehrq", 4'(HRQ), 4'd1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
